fb_write_arbiter: RTL

- Owns the single write port of the GPU framebuffer BRAM on the AXI clock domain.
- Arbitrates between two requesters: AXI-side host pixel writes, and an internal clear engine started by the clear-framebuffer GPIO.
- The clear engine sweeps every framebuffer word with CLEAR_VALUE. Host writes are interleaved with the sweep so the CPU is never starved.
- Sits between the AXI slave write path and the framebuffer BRAM port A; the raster side (port B) is untouched.

---
 rtl/fb_write_arbiter.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/fb_write_arbiter.sv
// -----------------------------------------------------------------------------
// fb_write_arbiter
//
// Owns the single write port (port A) of the GPU framebuffer BRAM on the AXI
// clock domain. Two requesters share it:
//   * host pixel writes coming from the AXI slave write path
//   * a clear engine that sweeps every framebuffer word with CLEAR_VALUE,
//     started by a rising edge on the clear-framebuffer GPIO level
// While a sweep runs, the host and the sweep alternate so the CPU is never
// starved: after every host grant the next cycle belongs to the sweep.
//
// Optional feature (macro FB_ARB_PERF_EN):
//   defined     -> stall_cycles counts cycles with wr_req_valid && !wr_req_ready,
//                  saturating at 16'hFFFF, cleared by reset or a clear start
//   not defined -> stall_cycles is tied to 0
//
// Ports:
//   S_AXI_ACLK      in   clock
//   S_AXI_ARESETN   in   asynchronous active-low reset
//   clear_req       in   clear request level; rising edge starts a sweep
//   clear_busy      out  high while the sweep is in progress
//   clear_done      out  one-cycle pulse when the sweep completes
//   wr_req_valid    in   host write request
//   wr_req_ready    out  host write accepted when valid && ready
//   wr_req_addr     in   host word address
//   wr_req_data     in   host write data
//   wr_req_strb     in   host byte enables
//   err_oob         out  one-cycle pulse when an out-of-range host write is dropped
//   bram_en         out  BRAM port enable
//   bram_we         out  BRAM byte write enables
//   bram_addr       out  BRAM word address
//   bram_din        out  BRAM write data
//   stall_cycles    out  host stall counter
// -----------------------------------------------------------------------------
module fb_write_arbiter #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 17,
    parameter int                    FB_WORDS    = 76800,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                      S_AXI_ACLK,
    input  logic                      S_AXI_ARESETN,
    input  logic                      clear_req,
    output logic                      clear_busy,
    output logic                      clear_done,
    input  logic                      wr_req_valid,
    output logic                      wr_req_ready,
    input  logic [ADDR_WIDTH-1:0]     wr_req_addr,
    input  logic [DATA_WIDTH-1:0]     wr_req_data,
    input  logic [DATA_WIDTH/8-1:0]   wr_req_strb,
    output logic                      err_oob,
    output logic                      bram_en,
    output logic [DATA_WIDTH/8-1:0]   bram_we,
    output logic [ADDR_WIDTH-1:0]     bram_addr,
    output logic [DATA_WIDTH-1:0]     bram_din,
    output logic [15:0]               stall_cycles
);

    localparam int STRB_W = DATA_WIDTH / 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // One extra bit so FB_WORDS == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0]   FB_WORDS_X = (ADDR_WIDTH+1)'(FB_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(FB_WORDS - 1);

    logic [0:0]            state_q,     state_d;
    logic [ADDR_WIDTH-1:0] counter_q,   counter_d;
    logic                  host_last_q, host_last_d;
    logic                  clear_req_q;
    logic                  busy_q,      busy_d;
    logic                  done_q,      done_d;
    logic                  oob_q,       oob_d;
    logic                  en_q,        en_d;
    logic [STRB_W-1:0]     we_q,        we_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [DATA_WIDTH-1:0] din_q,       din_d;

    logic start;
    logic host_go;
    logic clear_go;
    logic addr_oob;
    logic clear_last;

    assign start      = clear_req && !clear_req_q;
    // Ready depends only on registered state, never on wr_req_valid.
    assign wr_req_ready = (state_q == ST_IDLE) || !host_last_q;
    assign host_go    = wr_req_valid && wr_req_ready;
    // The sweep takes every CLEAR slot the host does not use.
    assign clear_go   = (state_q == ST_CLEAR) && !host_go;
    assign addr_oob   = {1'b0, wr_req_addr} >= FB_WORDS_X;
    assign clear_last = (counter_q == LAST_ADDR);

    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        host_last_d = host_last_q;
        done_d      = 1'b0;
        oob_d       = 1'b0;
        en_d        = 1'b0;
        we_d        = '0;
        addr_d      = addr_q;
        din_d       = din_q;

        // Port A issue for this cycle's grant (registered, visible next cycle).
        if (host_go) begin
            addr_d = wr_req_addr;
            din_d  = wr_req_data;
            if (addr_oob) begin
                // Accepted so the AXI side completes, but never reaches BRAM.
                oob_d = 1'b1;
            end else begin
                en_d = 1'b1;
                we_d = wr_req_strb;
            end
        end else if (clear_go) begin
            en_d   = 1'b1;
            we_d   = '1;
            addr_d = counter_q;
            din_d  = CLEAR_VALUE;
        end

        case (state_q)
            ST_IDLE: begin
                host_last_d = 1'b0;
                if (start) begin
                    state_d   = ST_CLEAR;
                    counter_d = '0;
                end
            end
            default: begin
                host_last_d = host_go;
                if (start) begin
                    // Restart the sweep; the aborted pass never signals done.
                    counter_d = '0;
                end else if (clear_go) begin
                    if (clear_last) begin
                        state_d   = ST_IDLE;
                        counter_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        counter_d = counter_q + ADDR_WIDTH'(1);
                    end
                end
            end
        endcase

        busy_d = (state_d == ST_CLEAR);
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q     <= ST_IDLE;
            counter_q   <= '0;
            host_last_q <= 1'b0;
            clear_req_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            oob_q       <= 1'b0;
            en_q        <= 1'b0;
            we_q        <= '0;
            addr_q      <= '0;
            din_q       <= '0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            host_last_q <= host_last_d;
            clear_req_q <= clear_req;
            busy_q      <= busy_d;
            done_q      <= done_d;
            oob_q       <= oob_d;
            en_q        <= en_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
        end
    end

    assign clear_busy = busy_q;
    assign clear_done = done_q;
    assign err_oob    = oob_q;
    assign bram_en    = en_q;
    assign bram_we    = we_q;
    assign bram_addr  = addr_q;
    assign bram_din   = din_q;

`ifdef FB_ARB_PERF_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start) begin
            stall_d = 16'h0000;
        end else if (wr_req_valid && !wr_req_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            stall_q <= 16'h0000;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 16'h0000;
`endif

endmodule
